// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the slave receiver and the master transmitter.
//   i2c_rx_state_t : receiver FSM states
//   I2C_ADDR_W     : 7-bit address width
//   I2C_DATA_W     : data byte width
//   ACK / NACK     : SDA level for the acknowledge bit
//   ack_to_oe()    : maps an acknowledge level onto the open-drain pull-down enable
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } i2c_rx_state_t;

  // Open-drain: only a low level is actively driven.
  function automatic logic ack_to_oe(input logic ack_level);
    return ack_level == 1'b0;
  endfunction

endpackage

// File: rtl/i2c_slave_receiver_if.sv
// Bus and local-side signals of the I2C slave receiver.
//   scl_in, sda_in : pad-level SCL/SDA (pulled-up bus values)
//   sda_oe         : 1 = pull SDA low
//   rx_ready       : local logic can accept a byte
//   rx_data        : last accepted data byte
//   rx_valid       : one-cycle strobe, rx_data updated and ACKed
//   busy           : addressed transaction in progress
//   addr_nack      : one-cycle strobe, read request to this address refused
interface i2c_slave_receiver_if;
  import i2c_pkg::*;

  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic                  rx_ready;
  logic [I2C_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  addr_nack;

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output sda_oe, rx_data, rx_valid, busy, addr_nack
  );

  modport master (
    output scl_in, sda_in, rx_ready,
    input  sda_oe, rx_data, rx_valid, busy, addr_nack
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer plus history flop for one I2C line.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous pad level
//   level    : synchronized level
//   rise     : synced level went 0->1 this cycle
//   fall     : synced level went 1->0 this cycle
// All flops reset to 1 so an idle (pulled-up) bus produces no spurious edges.
module i2c_line_sync #(
  parameter int unsigned STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave receiver.
//   clk : system clock, at least 8x SCL
//   rst : asynchronous active-high reset
//   bus : i2c_slave_receiver_if.slave (SCL/SDA in, SDA pull-down, byte strobe handshake)
// START/STOP are honoured in every state and override bit events in the same cycle.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  i2c_slave_receiver_if.slave  bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_rx_state_t         state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic [I2C_DATA_W-1:0] data_q, data_d;
  logic                  oe_q, oe_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  nack_q, nack_d;
  logic [I2C_DATA_W-1:0] byte_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    oe_d    = oe_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    nack_d  = 1'b0;
    // Byte as it stands including the bit sampled on this SCL rise.
    byte_in = {shift_q[I2C_DATA_W-2:0], sda_lvl};

    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      // busy is left alone until the new address is evaluated.
      state_d = StAddr;
      cnt_d   = 4'd0;
      shift_d = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StData: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = 4'(cnt_q + 4'd1);
            if (cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                if (byte_in[7:1] == SLAVE_ADDR && byte_in[0] == 1'b0) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                  nack_d  = (byte_in[7:1] == SLAVE_ADDR);
                end
              end else if (bus.rx_ready) begin
                data_d  = byte_in;
                valid_d = 1'b1;
                state_d = StDataAck;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddrAck, StDataAck: begin
          // oe_q doubles as the phase flag: first SCL fall pulls, second releases.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = ack_to_oe(ACK);
            end else begin
              oe_d    = ack_to_oe(NACK);
              state_d = StData;
              cnt_d   = 4'd0;
              shift_d = '0;
            end
          end
        end
        StIgnore: oe_d = 1'b0;
        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.busy      = busy_q;
  assign bus.addr_nack = nack_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Scoreboard bench for i2c_slave_receiver: bit-banged master, open-drain bus model.
module tb_i2c_slave_receiver;
  import i2c_pkg::*;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic ready = 1'b1;

  i2c_slave_receiver_if bus();

  assign bus.scl_in   = scl_m;
  assign bus.sda_in   = sda_m & ~bus.sda_oe;
  assign bus.rx_ready = ready;

  i2c_slave_receiver #(
    .SLAVE_ADDR  (7'h42),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nack_seen = 0;
  bit oe_seen = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid strobe pops one expected byte.
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %h expected no strobe", bus.rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_data_strobe", bus.rx_data, mon_exp);
      end
    end
    if (bus.addr_nack) nack_seen++;
    if (bus.sda_oe) oe_seen = 1'b1;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    if (!scl_m) begin
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
    end
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = v[i]; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
    end
  endtask

  // Ninth clock: master releases SDA and checks the slave's pull-down mid-high.
  task automatic ack_clock(input string name, input logic exp_oe);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    check(name, {7'd0, bus.sda_oe}, {7'd0, exp_oe});
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] v, input string name, input logic exp_oe);
    send_bits(v, 8);
    ack_clock(name, exp_oe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sda_oe", {7'd0, bus.sda_oe}, 8'd0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", {7'd0, bus.rx_valid}, 8'd0);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_addr_nack", {7'd0, bus.addr_nack}, 8'd0);
    rst = 1'b0;
    wq();

    // Write 0x42 / 0xA5
    start_cond();
    send_byte(8'h84, "t1_addr_ack", 1'b1);
    check("t1_oe_released", {7'd0, bus.sda_oe}, 8'd0);
    check("t1_busy_after_ack", {7'd0, bus.busy}, 8'd1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, "t1_data_ack", 1'b1);
    check("t1_busy_before_stop", {7'd0, bus.busy}, 8'd1);
    stop_cond();
    check("t1_busy_after_stop", {7'd0, bus.busy}, 8'd0);
    check("t1_rx_data", bus.rx_data, 8'hA5);

    // Wrong address 0x43
    oe_seen = 1'b0;
    start_cond();
    send_byte(8'h86, "t2_addr_nack", 1'b0);
    send_byte(8'h11, "t2_data_nack", 1'b0);
    check("t2_busy", {7'd0, bus.busy}, 8'd0);
    stop_cond();
    check("t2_oe_never", {7'd0, oe_seen}, 8'd0);

    // Read request to own address
    n0 = nack_seen;
    start_cond();
    send_byte(8'h85, "t3_read_nack", 1'b0);
    stop_cond();
    check("t3_addr_nack_count", 8'(nack_seen - n0), 8'd1);

    // Three bytes, back-pressure on the third
    start_cond();
    send_byte(8'h84, "t4_addr_ack", 1'b1);
    exp_q.push_back(8'h01);
    send_byte(8'h01, "t4_b1_ack", 1'b1);
    exp_q.push_back(8'h02);
    send_byte(8'h02, "t4_b2_ack", 1'b1);
    ready = 1'b0;
    send_byte(8'h03, "t4_b3_nack", 1'b0);
    check("t4_rx_data_kept", bus.rx_data, 8'h02);
    stop_cond();
    ready = 1'b1;

    // Partial byte then fresh transaction
    start_cond();
    send_byte(8'h84, "t5_addr_ack", 1'b1);
    send_bits(8'hB0, 5);
    stop_cond();
    check("t5_partial_no_update", bus.rx_data, 8'h02);
    start_cond();
    send_byte(8'h84, "t5_addr2_ack", 1'b1);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, "t5_data_ack", 1'b1);
    stop_cond();
    check("t5_rx_data", bus.rx_data, 8'h7E);

    // Async reset during address ACK
    start_cond();
    send_bits(8'h84, 8);
    wq();
    check("t6_oe_before_rst", {7'd0, bus.sda_oe}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_oe", {7'd0, bus.sda_oe}, 8'd0);
    check("t6_rst_busy", {7'd0, bus.busy}, 8'd0);
    check("t6_rst_rx_data", bus.rx_data, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wq();
    start_cond();
    send_byte(8'h84, "t6_addr_ack", 1'b1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, "t6_data_ack", 1'b1);
    stop_cond();
    check("t6_rx_data", bus.rx_data, 8'h5A);

    wq();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_receiver.md
Name: i2c_slave_receiver

Overview:
Write-only I2C slave that consumes the SCL/SDA stream produced by the team's I2C master transmitter. It detects START and STOP, matches a 7-bit address, accepts one or more data bytes per transaction, and drives ACK/NACK by open-drain pull-down on SDA. Received bytes are presented to local logic as a single-cycle strobe, with a ready-based accept/NACK handshake.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit address this slave responds to
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2)

Ports:
clk  input  1  system clock; must run at ≥8x the SCL frequency
rst  input  1  asynchronous, active-high reset
scl_in  input  1  SCL line as seen at pad (pulled-up bus value)
sda_in  input  1  SDA line as seen at pad (pulled-up bus value)
sda_oe  output  1  1 = pull SDA low (ACK); 0 = release (high-Z)
rx_ready  input  1  local logic can accept a byte; sampled when deciding the data ACK
rx_data  output  8  last accepted data byte, MSB first on the wire
rx_valid  output  1  one-cycle strobe: rx_data updated and ACKed
busy  output  1  1 from a START addressed to this slave until STOP
addr_nack  output  1  one-cycle strobe: address matched but R/W=1 (read unsupported), NACKed

Behaviour:
- Reset (async, active-high): state=IDLE; sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, addr_nack=0; synchronizer and history flops reset to 1 (idle bus).
- Input path: SYNC_STAGES flops per line, then one history flop; rise/fall events = synced vs history. All decisions use the synced values only. Event detected in cycle N takes effect at the clock edge ending cycle N.
- START: SDA fall while synced SCL=1. STOP: SDA rise while synced SCL=1. Both are recognised in every state and take priority over bit events in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START -> ADDR, bit counter=0, shift register cleared.
- ADDR: on each SCL rise, shift sda into shift[0] (MSB first). After the 8th rise: {addr[6:0], rw} captured. Match and rw=0 -> ADDR_ACK, busy=1. Match and rw=1 -> pulse addr_nack, -> IGNORE (no ACK). Mismatch -> IGNORE.
- ADDR_ACK / DATA_ACK: sda_oe is asserted on the SCL fall that follows the 8th rise. It is held through the 9th SCL high phase and released on the next SCL fall, then -> DATA with counter=0.
- DATA: 8 rises shifted as above. On the 8th rise, rx_ready is sampled. If it is 1: rx_data<=shift, rx_valid pulses the next cycle, -> DATA_ACK. If it is 0: byte dropped, no strobe, -> IGNORE (NACK; master is expected to STOP).
- IGNORE: sda_oe=0. Wait for STOP -> IDLE, or repeated START -> ADDR.
- STOP in any state: -> IDLE, sda_oe=0 immediately, busy=0. A partial byte (<8 bits) is discarded with no rx_valid.
- Repeated START in any state: -> ADDR, counter=0, sda_oe=0, busy held until address evaluated (then set or cleared per match).
- Bit counter: 4 bits, counts 0..8, never wraps past 8. The SDA transition during SCL low is ignored; only rises sample data.
- sda_oe never changes while synced SCL=1, except STOP/START aborts (defensive).
- Reset mid-transfer: all outputs return to reset values within the async assertion; no strobe is generated.

Decomposition:
- Package i2c_pkg: state enum typedef (i2c_rx_state_t), I2C_ADDR_W=7, I2C_DATA_W=8, ACK=1'b0/NACK=1'b1 constants. This package is shared with the master transmitter.
- Sub-module i2c_line_sync: parameterised synchronizer plus history flop, outputting synced level, rise and fall for one line. Instantiated twice (SCL, SDA).

Test Plan:
- Write 0x42 then 0xA5, rx_ready=1, STOP -> sda_oe low during both 9th clocks; one rx_valid with rx_data=8'hA5; busy 1 from address ACK until STOP, then 0.
- Address 0x43 then byte 0x11 -> sda_oe stays 0 throughout; no rx_valid; busy stays 0; returns to IDLE on STOP.
- Address 0x42 with R/W=1 -> addr_nack strobes once; sda_oe 0 on 9th clock; no rx_valid.
- Address 0x42, bytes 0x01, 0x02, 0x03; rx_ready dropped to 0 before byte 3 -> rx_valid for 0x01 and 0x02 only; byte 3 NACKed (sda_oe 0 on its 9th clock); rx_data stays 8'h02.
- Address 0x42, STOP after 5 data bits, then a new START with 0x42 and byte 0x7E -> no strobe for the partial byte; rx_valid with 8'h7E.
- rst asserted mid-byte during an ACK phase (sda_oe=1) -> sda_oe=0 and busy=0 asynchronously; after release, a full 0x42/0x5A write gives rx_data=8'h5A.
